// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control-unit <-> multi-cycle datapath bundle (IR fields in, strobes/selects/status out).
// Carries mem_ready only when MC_MEM_WAIT_EN is defined.
interface mc_ctrl_if #(
    parameter int unsigned ALUCTR_W = 5,
    parameter int unsigned CNT_W    = 32
);
    logic [5:0]          op;
    logic [5:0]          func;
`ifdef MC_MEM_WAIT_EN
    logic                mem_ready;
`endif
    logic                PCWr;
    logic                IRWr;
    logic                RegWr;
    logic                MemWr;
    logic                Branch;
    logic                Jump;
    logic                RegDst;
    logic                ALUSrc;
    logic                MemtoReg;
    logic                Link;
    logic [1:0]          ExtOp;
    logic [1:0]          MemType;
    logic [ALUCTR_W-1:0] ALUctr;
    logic [2:0]          state;
    logic                done;
    logic                illegal;
    logic [CNT_W-1:0]    instret;

`ifdef MC_MEM_WAIT_EN
    modport master (
        input  op, func, mem_ready,
        output PCWr, IRWr, RegWr, MemWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, Link,
               ExtOp, MemType, ALUctr, state, done, illegal, instret
    );
    modport slave (
        output op, func, mem_ready,
        input  PCWr, IRWr, RegWr, MemWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, Link,
               ExtOp, MemType, ALUctr, state, done, illegal, instret
    );
`else
    modport master (
        input  op, func,
        output PCWr, IRWr, RegWr, MemWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, Link,
               ExtOp, MemType, ALUctr, state, done, illegal, instret
    );
    modport slave (
        output op, func,
        input  PCWr, IRWr, RegWr, MemWr, Branch, Jump, RegDst, ALUSrc, MemtoReg, Link,
               ExtOp, MemType, ALUctr, state, done, illegal, instret
    );
`endif
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit sequencing IF/ID/EXE/MEM/WB, with a retired-instruction counter.
// Define MC_MEM_WAIT_EN to hold MEM until mem_ready is high.
module mc_ctrl #(
    parameter int unsigned ALUCTR_W = 5,
    parameter int unsigned CNT_W    = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        C_ILL, C_ALU, C_LD, C_ST, C_BR, C_J, C_JAL, C_JR, C_JALR
    } class_e;

    localparam logic [ALUCTR_W-1:0] A_ADD  = ALUCTR_W'(0);
    localparam logic [ALUCTR_W-1:0] A_SUB  = ALUCTR_W'(1);
    localparam logic [ALUCTR_W-1:0] A_SLT  = ALUCTR_W'(2);
    localparam logic [ALUCTR_W-1:0] A_AND  = ALUCTR_W'(3);
    localparam logic [ALUCTR_W-1:0] A_NOR  = ALUCTR_W'(4);
    localparam logic [ALUCTR_W-1:0] A_OR   = ALUCTR_W'(5);
    localparam logic [ALUCTR_W-1:0] A_XOR  = ALUCTR_W'(6);
    localparam logic [ALUCTR_W-1:0] A_SLL  = ALUCTR_W'(7);
    localparam logic [ALUCTR_W-1:0] A_SRL  = ALUCTR_W'(8);
    localparam logic [ALUCTR_W-1:0] A_SLTU = ALUCTR_W'(9);
    localparam logic [ALUCTR_W-1:0] A_SLLV = ALUCTR_W'(12);
    localparam logic [ALUCTR_W-1:0] A_SRA  = ALUCTR_W'(13);
    localparam logic [ALUCTR_W-1:0] A_SRAV = ALUCTR_W'(14);
    localparam logic [ALUCTR_W-1:0] A_SRLV = ALUCTR_W'(15);

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [1:0] MT_WORD  = 2'b00;
    localparam logic [1:0] MT_BYTE  = 2'b01;
    localparam logic [1:0] MT_UBYTE = 2'b10;

    state_e           state_q;
    logic [CNT_W-1:0] instret_q;

    class_e                cls_c;
    logic                  reg_dst_c, alu_src_c, mem_to_reg_c;
    logic [1:0]            ext_op_c, mem_type_c;
    logic [ALUCTR_W-1:0]   alu_ctr_c;
    logic                  pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c, branch_c, jump_c, link_c;
    logic                  done_c, illegal_c;
    logic                  mem_go_c;

`ifdef MC_MEM_WAIT_EN
    assign mem_go_c = bus.mem_ready;
`else
    assign mem_go_c = 1'b1;
`endif

    // Instruction class and datapath selects, purely from the IR fields.
    always_comb begin
        cls_c        = C_ILL;
        reg_dst_c    = 1'b0;
        alu_src_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        ext_op_c     = EXT_ZERO;
        mem_type_c   = MT_WORD;
        alu_ctr_c    = A_ADD;
        case (bus.op)
            6'h00: begin
                cls_c     = C_ALU;
                reg_dst_c = 1'b1;
                case (bus.func)
                    6'h00:   alu_ctr_c = A_SLL;
                    6'h02:   alu_ctr_c = A_SRL;
                    6'h03:   alu_ctr_c = A_SRA;
                    6'h04:   alu_ctr_c = A_SLLV;
                    6'h06:   alu_ctr_c = A_SRLV;
                    6'h07:   alu_ctr_c = A_SRAV;
                    6'h08:   cls_c     = C_JR;
                    6'h09:   cls_c     = C_JALR;
                    6'h21:   alu_ctr_c = A_ADD;
                    6'h23:   alu_ctr_c = A_SUB;
                    6'h24:   alu_ctr_c = A_AND;
                    6'h25:   alu_ctr_c = A_OR;
                    6'h26:   alu_ctr_c = A_XOR;
                    6'h27:   alu_ctr_c = A_NOR;
                    6'h2A:   alu_ctr_c = A_SLT;
                    6'h2B:   alu_ctr_c = A_SLTU;
                    default: cls_c     = C_ILL;
                endcase
            end
            6'h02: cls_c = C_J;
            6'h03: cls_c = C_JAL;
            6'h01, 6'h06, 6'h07: begin
                cls_c    = C_BR;
                ext_op_c = EXT_SIGN;
            end
            6'h04, 6'h05: begin
                cls_c     = C_BR;
                ext_op_c  = EXT_SIGN;
                alu_ctr_c = A_SUB;
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                cls_c     = C_ALU;
                alu_src_c = 1'b1;
                case (bus.op[2:0])
                    3'd1:    begin alu_ctr_c = A_ADD;  ext_op_c = EXT_SIGN; end
                    3'd2:    begin alu_ctr_c = A_SLT;  ext_op_c = EXT_SIGN; end
                    3'd3:    begin alu_ctr_c = A_SLTU; ext_op_c = EXT_SIGN; end
                    3'd4:    alu_ctr_c = A_AND;
                    3'd5:    alu_ctr_c = A_OR;
                    3'd6:    alu_ctr_c = A_XOR;
                    default: begin alu_ctr_c = A_OR;   ext_op_c = EXT_LUI;  end
                endcase
            end
            6'h20, 6'h23, 6'h24: begin
                cls_c        = C_LD;
                alu_src_c    = 1'b1;
                mem_to_reg_c = 1'b1;
                ext_op_c     = EXT_SIGN;
                mem_type_c   = (bus.op == 6'h20) ? MT_BYTE :
                               (bus.op == 6'h24) ? MT_UBYTE : MT_WORD;
            end
            6'h28, 6'h2B: begin
                cls_c      = C_ST;
                alu_src_c  = 1'b1;
                ext_op_c   = EXT_SIGN;
                mem_type_c = (bus.op == 6'h28) ? MT_BYTE : MT_WORD;
            end
            default: cls_c = C_ILL;
        endcase
    end

    // Moore strobes from state and class; reset forces everything quiet even though state reads IF.
    always_comb begin
        pc_wr_c   = 1'b0;
        ir_wr_c   = 1'b0;
        reg_wr_c  = 1'b0;
        mem_wr_c  = 1'b0;
        branch_c  = 1'b0;
        jump_c    = 1'b0;
        link_c    = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    pc_wr_c = 1'b1;
                    ir_wr_c = 1'b1;
                end
                S_ID: begin
                    case (cls_c)
                        C_J, C_JR: begin
                            jump_c  = 1'b1;
                            pc_wr_c = 1'b1;
                            done_c  = 1'b1;
                        end
                        C_JAL, C_JALR: begin
                            jump_c   = 1'b1;
                            pc_wr_c  = 1'b1;
                            reg_wr_c = 1'b1;
                            link_c   = 1'b1;
                            done_c   = 1'b1;
                        end
                        C_ILL:   illegal_c = 1'b1;
                        default: ;
                    endcase
                end
                S_EXE: begin
                    if (cls_c == C_BR) begin
                        branch_c = 1'b1;
                        done_c   = 1'b1;
                    end
                end
                S_MEM: begin
                    if (cls_c == C_ST) begin
                        mem_wr_c = 1'b1;
                        done_c   = mem_go_c;
                    end
                end
                S_WB: begin
                    reg_wr_c = 1'b1;
                    done_c   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            instret_q <= '0;
        end else begin
            if (done_c) instret_q <= instret_q + CNT_W'(1);
            case (state_q)
                S_IF:  state_q <= S_ID;
                S_ID:  state_q <= (cls_c inside {C_ILL, C_J, C_JAL, C_JR, C_JALR}) ? S_IF : S_EXE;
                S_EXE: state_q <= (cls_c inside {C_LD, C_ST}) ? S_MEM :
                                  (cls_c == C_ALU)            ? S_WB  : S_IF;
                S_MEM: if (mem_go_c) state_q <= (cls_c == C_LD) ? S_WB : S_IF;
                default: state_q <= S_IF;
            endcase
        end
    end

    assign bus.PCWr     = pc_wr_c;
    assign bus.IRWr     = ir_wr_c;
    assign bus.RegWr    = reg_wr_c;
    assign bus.MemWr    = mem_wr_c;
    assign bus.Branch   = branch_c;
    assign bus.Jump     = jump_c;
    assign bus.Link     = link_c;
    assign bus.RegDst   = reg_dst_c;
    assign bus.ALUSrc   = alu_src_c;
    assign bus.MemtoReg = mem_to_reg_c;
    assign bus.ExtOp    = ext_op_c;
    assign bus.MemType  = mem_type_c;
    assign bus.ALUctr   = alu_ctr_c;
    assign bus.state    = state_q;
    assign bus.done     = done_c;
    assign bus.illegal  = illegal_c;
    assign bus.instret  = instret_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed scoreboard bench for mc_ctrl; a second instance with a 4-bit counter exercises wrap.
module tb_mc_ctrl;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_J = 4, K_JAL = 5, K_ILL = 6;

    localparam logic [8:0] B_PC = 9'h100, B_IR = 9'h080, B_RW = 9'h040, B_MW = 9'h020;
    localparam logic [8:0] B_BR = 9'h010, B_JP = 9'h008, B_LK = 9'h004, B_DN = 9'h002, B_IL = 9'h001;

    typedef struct {
        logic [11:0] vec;
        logic [31:0] cnt;
        logic        mrdy;
    } exp_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  func;
        int          kind;
        logic [11:0] dec;
        logic [11:0] mask;
    } instr_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_cnt = 32'd0;
    exp_t   sb[$];
    instr_t tbl[$];

    always #5 clk = ~clk;

    mc_ctrl_if #(.ALUCTR_W(5), .CNT_W(32)) bus ();
    mc_ctrl_if #(.ALUCTR_W(5), .CNT_W(4))  bus4 ();

    mc_ctrl #(.ALUCTR_W(5), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mc_ctrl #(.ALUCTR_W(5), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    function automatic logic [11:0] obs_vec();
        return {bus.state, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.Branch,
                bus.Jump, bus.Link, bus.done, bus.illegal};
    endfunction

    function automatic logic [11:0] obs_dec();
        return {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.ExtOp, bus.MemType, bus.ALUctr};
    endfunction

    function automatic logic [11:0] d(logic rd, logic as, logic m2r, logic [1:0] ext,
                                      logic [1:0] mt, logic [4:0] alu);
        return {rd, as, m2r, ext, mt, alu};
    endfunction

    function automatic instr_t mk_i(string n, logic [5:0] op, logic [5:0] func, int kind,
                                    logic [11:0] dec, logic [11:0] mask);
        instr_t t;
        t.name = n; t.op = op; t.func = func; t.kind = kind; t.dec = dec; t.mask = mask;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [8:0] s, input logic mr);
        exp_t e;
        e.vec = {st, s}; e.cnt = exp_cnt; e.mrdy = mr;
        sb.push_back(e);
        if ((s & B_DN) != 9'd0) exp_cnt = exp_cnt + 32'd1;
    endtask

    // Expected per-cycle state/strobe trace for one instruction of the given kind.
    task automatic push_seq(input int kind, input int holds);
        push(3'd0, B_PC | B_IR, 1'b1);
        case (kind)
            K_ALU: begin push(3'd1, 9'd0, 1'b1); push(3'd2, 9'd0, 1'b1); push(3'd4, B_RW | B_DN, 1'b1); end
            K_LD: begin
                push(3'd1, 9'd0, 1'b1); push(3'd2, 9'd0, 1'b1);
                for (int h = 0; h < holds; h++) push(3'd3, 9'd0, 1'b0);
                push(3'd3, 9'd0, 1'b1); push(3'd4, B_RW | B_DN, 1'b1);
            end
            K_ST: begin
                push(3'd1, 9'd0, 1'b1); push(3'd2, 9'd0, 1'b1);
                for (int h = 0; h < holds; h++) push(3'd3, B_MW, 1'b0);
                push(3'd3, B_MW | B_DN, 1'b1);
            end
            K_BR:    begin push(3'd1, 9'd0, 1'b1); push(3'd2, B_BR | B_DN, 1'b1); end
            K_J:     push(3'd1, B_PC | B_JP | B_DN, 1'b1);
            K_JAL:   push(3'd1, B_PC | B_JP | B_RW | B_LK | B_DN, 1'b1);
            default: push(3'd1, B_IL, 1'b1);
        endcase
    endtask

    // Called at posedge+1 with the DUT in IF; returns at posedge+1 of the following IF.
    task automatic run(input instr_t t, input int holds);
        exp_t e;
        bus.op = t.op; bus.func = t.func; bus4.op = t.op; bus4.func = t.func;
        push_seq(t.kind, holds);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
`ifdef MC_MEM_WAIT_EN
            bus.mem_ready = e.mrdy; bus4.mem_ready = e.mrdy;
`endif
            @(negedge clk);
            chk($sformatf("%s/c%0d/vec", t.name, c), 32'(obs_vec()), 32'(e.vec));
            chk($sformatf("%s/c%0d/instret", t.name, c), bus.instret, e.cnt);
            chk($sformatf("%s/c%0d/instret4", t.name, c), 32'(bus4.instret), 32'(e.cnt[3:0]));
            if (c == 1 && t.mask != 12'd0)
                chk($sformatf("%s/decode", t.name), 32'(obs_dec() & t.mask), 32'(t.dec & t.mask));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t addu;
        rst = 1'b1;
        bus.op = 6'h00; bus.func = 6'h00; bus4.op = 6'h00; bus4.func = 6'h00;
`ifdef MC_MEM_WAIT_EN
        bus.mem_ready = 1'b1; bus4.mem_ready = 1'b1;
`endif
        addu = mk_i("addu", 6'h00, 6'h21, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0), 12'hE1F);
        tbl.push_back(addu);
        tbl.push_back(mk_i("lw",    6'h23, 6'h00, K_LD,  d(1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 5'd0),  12'hFFF));
        tbl.push_back(mk_i("sb",    6'h28, 6'h15, K_ST,  d(1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 5'd0),  12'h5FF));
        tbl.push_back(mk_i("beq",   6'h04, 6'h15, K_BR,  d(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 5'd1),  12'h59F));
        tbl.push_back(mk_i("jal",   6'h03, 6'h15, K_JAL, d(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0),  12'h01F));
        tbl.push_back(mk_i("ill3f", 6'h3F, 6'h21, K_ILL, 12'd0, 12'd0));
        tbl.push_back(mk_i("subu",  6'h00, 6'h23, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd1),  12'hE1F));
        tbl.push_back(mk_i("and",   6'h00, 6'h24, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd3),  12'hE1F));
        tbl.push_back(mk_i("or",    6'h00, 6'h25, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd5),  12'hE1F));
        tbl.push_back(mk_i("xor",   6'h00, 6'h26, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd6),  12'hE1F));
        tbl.push_back(mk_i("nor",   6'h00, 6'h27, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd4),  12'hE1F));
        tbl.push_back(mk_i("slt",   6'h00, 6'h2A, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd2),  12'hE1F));
        tbl.push_back(mk_i("sltu",  6'h00, 6'h2B, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd9),  12'hE1F));
        tbl.push_back(mk_i("sll",   6'h00, 6'h00, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd7),  12'hE1F));
        tbl.push_back(mk_i("srl",   6'h00, 6'h02, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd8),  12'hE1F));
        tbl.push_back(mk_i("sra",   6'h00, 6'h03, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd13), 12'hE1F));
        tbl.push_back(mk_i("sllv",  6'h00, 6'h04, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd12), 12'hE1F));
        tbl.push_back(mk_i("srlv",  6'h00, 6'h06, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd15), 12'hE1F));
        tbl.push_back(mk_i("srav",  6'h00, 6'h07, K_ALU, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd14), 12'hE1F));
        tbl.push_back(mk_i("addiu", 6'h09, 6'h21, K_ALU, d(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 5'd0),  12'hF9F));
        tbl.push_back(mk_i("slti",  6'h0A, 6'h00, K_ALU, d(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 5'd2),  12'hF9F));
        tbl.push_back(mk_i("sltiu", 6'h0B, 6'h00, K_ALU, d(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 5'd9),  12'hF9F));
        tbl.push_back(mk_i("andi",  6'h0C, 6'h00, K_ALU, d(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd3),  12'hF9F));
        tbl.push_back(mk_i("ori",   6'h0D, 6'h24, K_ALU, d(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd5),  12'hF9F));
        tbl.push_back(mk_i("xori",  6'h0E, 6'h00, K_ALU, d(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd6),  12'hF9F));
        tbl.push_back(mk_i("lui",   6'h0F, 6'h00, K_ALU, d(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 5'd5),  12'hF9F));
        tbl.push_back(mk_i("lb",    6'h20, 6'h00, K_LD,  d(1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 5'd0),  12'hFFF));
        tbl.push_back(mk_i("lbu",   6'h24, 6'h00, K_LD,  d(1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 5'd0),  12'hFFF));
        tbl.push_back(mk_i("sw",    6'h2B, 6'h00, K_ST,  d(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 5'd0),  12'h5FF));
        tbl.push_back(mk_i("bne",   6'h05, 6'h00, K_BR,  d(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 5'd1),  12'h59F));
        tbl.push_back(mk_i("blez",  6'h06, 6'h00, K_BR,  d(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 5'd0),  12'h580));
        tbl.push_back(mk_i("bgtz",  6'h07, 6'h00, K_BR,  d(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 5'd0),  12'h580));
        tbl.push_back(mk_i("regimm",6'h01, 6'h00, K_BR,  d(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 5'd0),  12'h580));
        tbl.push_back(mk_i("j",     6'h02, 6'h00, K_J,   12'd0, 12'd0));
        tbl.push_back(mk_i("jr",    6'h00, 6'h08, K_J,   12'd0, 12'd0));
        tbl.push_back(mk_i("jalr",  6'h00, 6'h09, K_JAL, d(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0),  12'h81F));
        tbl.push_back(mk_i("add",   6'h00, 6'h20, K_ILL, 12'd0, 12'd0));
        tbl.push_back(mk_i("ill11", 6'h11, 6'h00, K_ILL, 12'd0, 12'd0));

        // Held in reset: IF with everything quiet.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/vec", 32'(obs_vec()), 32'd0);
        chk("reset/instret", bus.instret, 32'd0);
        chk("reset/instret4", 32'(bus4.instret), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i], 0);

        // Reset asserted mid-EXE of addu abandons it.
        bus.op = 6'h00; bus.func = 6'h21; bus4.op = 6'h00; bus4.func = 6'h21;
        @(negedge clk); chk("rstmid/if", 32'(obs_vec()), 32'({3'd0, B_PC | B_IR}));
        @(posedge clk); #1;
        @(negedge clk); chk("rstmid/id", 32'(obs_vec()), 32'({3'd1, 9'd0}));
        @(posedge clk); #1;
        @(negedge clk); chk("rstmid/exe", 32'(obs_vec()), 32'({3'd2, 9'd0}));
        chk("rstmid/exe_instret", bus.instret, exp_cnt);
        rst = 1'b1;
        exp_cnt = 32'd0;
        #1;
        chk("rstmid/async_vec", 32'(obs_vec()), 32'd0);
        chk("rstmid/async_instret", bus.instret, 32'd0);
        chk("rstmid/async_instret4", 32'(bus4.instret), 32'd0);
        @(posedge clk); #1;
        chk("rstmid/held_vec", 32'(obs_vec()), 32'd0);
        rst = 1'b0;

        // Sixteen retirements: 4-bit counter returns to zero.
        for (int k = 0; k < 16; k++) run(addu, 0);
        chk("wrap/instret", bus.instret, 32'd16);
        chk("wrap/instret4", 32'(bus4.instret), 32'd0);

`ifdef MC_MEM_WAIT_EN
        run(mk_i("sw_wait", 6'h2B, 6'h00, K_ST, d(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 5'd0), 12'h5FF), 3);
        run(mk_i("lw_wait", 6'h23, 6'h00, K_LD, d(1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 5'd0), 12'hFFF), 2);
        run(addu, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
